// File: rtl/tff_consistency_checker.sv
// Consistency checker that tracks a reference T flip-flop and compares the D/SR/JK implementations against it.
// Optional sticky per-source mismatch flags are compiled in with `define TFF_CHK_PERSRC_EN.
module tff_consistency_checker #(
  parameter int CNT_W        = 8,
  parameter int MAX_MISMATCH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             t,
  input  logic             q_d,
  input  logic             q_sr,
  input  logic             q_jk,
  output logic [CNT_W-1:0] toggle_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             mis,
  output logic             err,
  output logic [1:0]       state,
  output logic [2:0]       mis_src
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FAIL = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIS_LIMIT = CNT_W'(MAX_MISMATCH);

  state_e           state_q, state_d;
  logic             q_ref_q, q_ref_d;
  logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;
  logic [2:0]       m_src_s;
  logic             mis_cyc_s;
  logic [CNT_W-1:0] mis_cnt_inc_s;

  // Compare against the reference value held before this edge's update.
  always_comb begin
    m_src_s       = {q_jk, q_sr, q_d} ^ {3{q_ref_q}};
    mis_cyc_s     = |m_src_s;
    mis_cnt_inc_s = (mis_cnt_q == CNT_MAX) ? mis_cnt_q : (mis_cnt_q + CNT_ONE);
  end

  always_comb begin
    q_ref_d   = q_ref_q ^ t;
    state_d   = state_q;
    tog_cnt_d = tog_cnt_q;
    mis_cnt_d = mis_cnt_q;
    mis_d     = 1'b0;
    if (clr) begin
      state_d   = ST_IDLE;
      tog_cnt_d = '0;
      mis_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_RUN;
          else    state_d = ST_IDLE;
        end
        ST_RUN: begin
          if (t && (tog_cnt_q != CNT_MAX)) tog_cnt_d = tog_cnt_q + CNT_ONE;
          else                             tog_cnt_d = tog_cnt_q;
          if (mis_cyc_s) begin
            mis_cnt_d = mis_cnt_inc_s;
            mis_d     = 1'b1;
          end else begin
            mis_cnt_d = mis_cnt_q;
          end
          // The threshold transition outranks an en-driven return to IDLE.
          if (mis_cyc_s && (mis_cnt_inc_s == MIS_LIMIT)) state_d = ST_FAIL;
          else if (!en)                                  state_d = ST_IDLE;
          else                                           state_d = ST_RUN;
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end
    err_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      q_ref_q   <= 1'b0;
      tog_cnt_q <= '0;
      mis_cnt_q <= '0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_ref_q   <= q_ref_d;
      tog_cnt_q <= tog_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
    end
  end

`ifdef TFF_CHK_PERSRC_EN
  logic [2:0] mis_src_q, mis_src_d;

  always_comb begin
    if (clr)                     mis_src_d = 3'b000;
    else if (state_q == ST_RUN)  mis_src_d = mis_src_q | m_src_s;
    else                         mis_src_d = mis_src_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_src_q <= 3'b000;
    else     mis_src_q <= mis_src_d;
  end

  assign mis_src = mis_src_q;
`else
  assign mis_src = 3'b000;
`endif

  assign toggle_count   = tog_cnt_q;
  assign mismatch_count = mis_cnt_q;
  assign mis            = mis_q;
  assign err            = err_q;
  assign state          = state_q;

endmodule

// File: tb/tb_tff_consistency_checker.sv
// Bench for tff_consistency_checker: directed vector table, corner sequences and random stimulus against a model.
module tb_tff_consistency_checker;

  localparam int MAXM = 3;

  logic clk;
  logic rst, en, clr, t, q_d, q_sr, q_jk;
  logic [7:0] tc0, mc0;
  logic [1:0] tc1, mc1;
  logic mis0, err0, mis1, err1;
  logic [1:0] st0, st1;
  logic [2:0] src0, src1;

  tff_consistency_checker #(.CNT_W(8), .MAX_MISMATCH(MAXM)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .t(t),
    .q_d(q_d), .q_sr(q_sr), .q_jk(q_jk),
    .toggle_count(tc0), .mismatch_count(mc0), .mis(mis0), .err(err0),
    .state(st0), .mis_src(src0)
  );

  tff_consistency_checker #(.CNT_W(2), .MAX_MISMATCH(MAXM)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .t(t),
    .q_d(q_d), .q_sr(q_sr), .q_jk(q_jk),
    .toggle_count(tc1), .mismatch_count(mc1), .mis(mis1), .err(err1),
    .state(st1), .mis_src(src1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: states 0=idle 1=run 2=fail; counters as plain integers.
  int       m_state [2];
  int       m_tc    [2];
  int       m_mc    [2];
  bit       m_mis   [2];
  bit [2:0] m_src   [2];
  int       m_sat   [2] = '{255, 3};
  int       t_total;
  bit       tff_q;

  typedef struct {
    bit       en;
    bit       clr;
    bit       t;
    bit [2:0] f;
    int       st;
    int       tc;
    int       mc;
    bit       mis;
    bit       err;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_tc[i] = 0; m_mc[i] = 0; m_mis[i] = 1'b0; m_src[i] = 3'b000;
    end
    t_total = 0;
    tff_q   = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit c, input bit tv, input bit [2:0] qv);
    bit       ref_b;
    bit [2:0] mm;
    ref_b = (t_total % 2) == 1;
    mm    = qv ^ {3{ref_b}};
    for (int i = 0; i < 2; i++) begin
      m_mis[i] = 1'b0;
      if (c) begin
        m_state[i] = 0; m_tc[i] = 0; m_mc[i] = 0; m_src[i] = 3'b000;
      end else if (m_state[i] == 0) begin
        if (e) m_state[i] = 1;
      end else if (m_state[i] == 1) begin
        if (tv && m_tc[i] < m_sat[i]) m_tc[i]++;
        if (mm != 3'b000) begin
          if (m_mc[i] < m_sat[i]) m_mc[i]++;
          m_mis[i] = 1'b1;
          m_src[i] = m_src[i] | mm;
        end
        if (mm != 3'b000 && m_mc[i] == MAXM) m_state[i] = 2;
        else if (!e) m_state[i] = 0;
      end
    end
    t_total += tv;
  endtask

  task automatic drive_edge(input bit e, input bit c, input bit tv, input bit [2:0] f);
    bit [2:0] qv;
    qv  = {3{tff_q}} ^ f;
    en  = e; clr = c; t = tv;
    {q_jk, q_sr, q_d} = qv;
    model_edge(e, c, tv, qv);
    @(posedge clk);
    #1;
    tff_q = tff_q ^ tv;
  endtask

  task automatic check_model(input string tag);
    bit [2:0] es0, es1;
`ifdef TFF_CHK_PERSRC_EN
    es0 = m_src[0]; es1 = m_src[1];
`else
    es0 = 3'b000; es1 = 3'b000;
`endif
    check({tag, ".state0"}, 32'(st0), 32'(m_state[0]));
    check({tag, ".tc0"},    32'(tc0), 32'(m_tc[0]));
    check({tag, ".mc0"},    32'(mc0), 32'(m_mc[0]));
    check({tag, ".mis0"},   32'(mis0), 32'(m_mis[0]));
    check({tag, ".err0"},   32'(err0), 32'(m_state[0] == 2));
    check({tag, ".src0"},   32'(src0), 32'(es0));
    check({tag, ".state1"}, 32'(st1), 32'(m_state[1]));
    check({tag, ".tc1"},    32'(tc1), 32'(m_tc[1]));
    check({tag, ".mc1"},    32'(mc1), 32'(m_mc[1]));
    check({tag, ".mis1"},   32'(mis1), 32'(m_mis[1]));
    check({tag, ".err1"},   32'(err1), 32'(m_state[1] == 2));
    check({tag, ".src1"},   32'(src1), 32'(es1));
  endtask

  initial begin
    //            en    clr   t     fault   st tc mc mis   err
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 3'b000, 1, 1, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 1, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 3'b000, 1, 2, 0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 2, 0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 3'b000, 1, 3, 0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 3'b000, 1, 4, 0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'b100, 1, 4, 1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1, 4, 1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'b001, 1, 4, 2, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 3'b010, 2, 4, 3, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 3'b000, 2, 4, 3, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 3'b111, 0, 0, 0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 0, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; clr = 1'b0; t = 1'b0;
    q_d = 1'b0; q_sr = 1'b0; q_jk = 1'b0;
    model_reset();
    #3;
    check_model("reset");
    #7;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive_edge(tbl[i].en, tbl[i].clr, tbl[i].t, tbl[i].f);
      check($sformatf("tbl%0d.state", i), 32'(st0), 32'(tbl[i].st));
      check($sformatf("tbl%0d.tc", i),    32'(tc0), 32'(tbl[i].tc));
      check($sformatf("tbl%0d.mc", i),    32'(mc0), 32'(tbl[i].mc));
      check($sformatf("tbl%0d.mis", i),   32'(mis0), 32'(tbl[i].mis));
      check($sformatf("tbl%0d.err", i),   32'(err0), 32'(tbl[i].err));
      check_model($sformatf("tbl%0d", i));
    end
`ifdef TFF_CHK_PERSRC_EN
    check("src_after_clr", 32'(src0), 32'(0));
`endif

    // Saturation of the 2-bit instance while the 8-bit one keeps counting.
    drive_edge(1'b1, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      drive_edge(1'b1, 1'b0, 1'b1, 3'b000);
      check_model($sformatf("sat%0d", i));
    end
    check("sat.tc0", 32'(tc0), 32'(5));
    check("sat.tc1", 32'(tc1), 32'(3));

    // Asynchronous reset in the middle of a cycle while in RUN.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst.state0", 32'(st0), 32'(0));
    check("arst.tc0",    32'(tc0), 32'(0));
    check_model("arst");
    #2;
    rst = 1'b0;
    drive_edge(1'b1, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 6; i++) begin
      drive_edge(1'b1, 1'b0, 1'(i % 2 == 0), 3'b000);
      check_model($sformatf("post_rst%0d", i));
    end
    check("post_rst.mc0", 32'(mc0), 32'(0));
    check("post_rst.state0", 32'(st0), 32'(1));

    for (int i = 0; i < 400; i++) begin
      bit       e, c, tv;
      bit [2:0] f;
      e  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 29) == 0);
      tv = 1'($urandom_range(0, 1));
      f  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      drive_edge(e, c, tv, f);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
